// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers in-order responses,
// and flushes on redirect. Define FETCHQ_BYPASS_EN to let a response reach the head in its own cycle.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_live;
  logic [CW-1:0] r_stale;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];

  logic [31:0]   w_redirect_pc;
  logic [SW-1:0] w_fill;
  logic [SW-1:0] w_flight;
  logic          w_req;
  logic          w_gnt;
  logic          w_stale_any;
  logic          w_live_resp;
  logic          w_empty;
  logic          w_bypass;
  logic          w_head_valid;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_fill        = {1'b0, r_count} + {1'b0, r_live};
  assign w_flight      = {1'b0, r_live} + {1'b0, r_stale};

  // Credit covers both FIFO space for live responses and the total outstanding limit.
  assign w_req       = reset && !redirect && (w_fill < DEPTH_S) && (w_flight < DEPTH_S);
  assign w_gnt       = w_req && imem_gnt;
  assign w_stale_any = (r_stale != '0);
  assign w_live_resp = imem_rvalid && !w_stale_any && !redirect;
  assign w_empty     = (r_count == '0);

`ifdef FETCHQ_BYPASS_EN
  assign w_bypass = w_empty && w_live_resp;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_head_valid = !w_empty || w_bypass;
  assign w_fire       = w_head_valid && instr_ready && !redirect;
  assign w_push       = w_live_resp && !(w_bypass && instr_ready);
  assign w_pop        = w_fire && !w_empty;

  assign imem_req    = w_req;
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = w_head_valid;

  always_comb begin
    instr    = 32'h0;
    instr_pc = 32'h0;
    if (w_bypass) begin
      instr    = imem_rdata;
      instr_pc = r_resp_pc;
    end else if (!w_empty) begin
      instr    = r_mem_instr[r_rd_ptr];
      instr_pc = r_mem_pc[r_rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_count    <= '0;
      r_live     <= '0;
      r_stale    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (redirect) begin
      // Everything in flight for the old stream becomes stale; the arriving response is dropped.
      r_fetch_pc <= w_redirect_pc;
      r_resp_pc  <= w_redirect_pc;
      r_count    <= '0;
      r_live     <= '0;
      r_stale    <= CW'(w_flight + SW'(w_gnt) - SW'(imem_rvalid));
      r_rd_ptr   <= r_wr_ptr;
    end else begin
      if (w_gnt) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_live_resp) begin
        r_resp_pc <= r_resp_pc + 32'd4;
      end
      r_live  <= r_live + CW'(w_gnt) - CW'(w_live_resp);
      r_stale <= r_stale - CW'(imem_rvalid && w_stale_any);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // NOTE: storage has no reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      assert (!(w_live_resp && r_count == DEPTH_C));
      assert (!(imem_rvalid && w_flight == '0));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: variable-latency memory model plus delivered-instruction log.
module tb_fetch_queue;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] KEY = 32'hA5C3_0F00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 1;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] gnt_addr[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  int          got_cyc[$];

  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        found;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Log this cycle's handshakes, advance one clock, then present any due memory response.
  task automatic cycle();
    if (imem_req && imem_gnt) begin
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + lat);
      gnt_addr.push_back(imem_addr);
    end
    if (instr_valid && instr_ready && !redirect) begin
      got_pc.push_back(instr_pc);
      got_instr.push_back(instr);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq_addr[0] ^ KEY;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    #1;
  endtask

  task automatic clear_logs();
    got_pc.delete();
    got_instr.delete();
    got_cyc.delete();
    gnt_addr.delete();
  endtask

  // Delivered instructions must be base, base+4, ... each carrying its own memory word.
  task automatic check_stream(input string tag, input logic [31:0] base, input int n);
    int bad;
    logic [31:0] e;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      e = base + 32'(4 * i);
      if (i >= got_pc.size()) bad++;
      else if (got_pc[i] !== e || got_instr[i] !== (e ^ KEY)) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    #1;
    check("req_low_on_redirect", {31'b0, imem_req}, 32'd0);
    cycle();
    redirect = 1'b0;
    #1;
  endtask

  initial begin
    // Reset values while held low
    #12;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_addr", imem_addr, RPC);

    @(negedge clk);
    reset       = 1'b1;
    instr_ready = 1'b1;
    #1;
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RPC);

    // Response-to-head latency on the first fetch
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (imem_rvalid) found = 1'b1;
    end
    check("first_resp_seen", {31'b0, found}, 32'd1);
`ifdef FETCHQ_BYPASS_EN
    check("bypass_valid", {31'b0, instr_valid}, 32'd1);
    check("bypass_pc", instr_pc, RPC);
`else
    check("resp_cycle_valid", {31'b0, instr_valid}, 32'd0);
    cycle();
    check("head_valid", {31'b0, instr_valid}, 32'd1);
    check("head_pc", instr_pc, RPC);
`endif
    for (int i = 0; i < 10; i++) cycle();
    check_stream("seq_stream", RPC, 8);
    check("seq_throughput", 32'(got_cyc[7] - got_cyc[0]), 32'd7);
    check("seq_gnt3", gnt_addr[3], RPC + 32'h0C);

    // Stall: queue fills, requests stop, head holds
    instr_ready = 1'b0;
    #1;
    hold_pc    = instr_pc;
    hold_instr = instr;
    clear_logs();
    for (int i = 0; i < 10; i++) cycle();
    check("stall_req", {31'b0, imem_req}, 32'd0);
    check("stall_valid", {31'b0, instr_valid}, 32'd1);
    check("stall_pc", instr_pc, hold_pc);
    check("stall_instr", instr, hold_instr);
    instr_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) cycle();
    check_stream("stall_release", hold_pc, 4);
    check("stall_burst", 32'(got_cyc[3] - got_cyc[0]), 32'd3);

    // 3-cycle memory, redirect with requests in flight
    lat = 3;
    for (int i = 0; i < 8; i++) cycle();
    clear_logs();
    do_redirect(32'h0000_0200);
    check("redir_req", {31'b0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h0000_0200);
    check("redir_valid", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 15; i++) cycle();
    check("redir_first_pc", got_pc[0], 32'h0000_0200);
    check_stream("redir_stream", 32'h0000_0200, 6);

    // Redirect in a cycle that carries a response and has grant asserted
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (imem_rvalid) found = 1'b1;
    end
    check("rv_redirect_found", {31'b0, found}, 32'd1);
    clear_logs();
    do_redirect(32'h0000_0240);
    for (int i = 0; i < 15; i++) cycle();
    check_stream("rv_redirect_stream", 32'h0000_0240, 6);

    // Two redirects one cycle apart
    clear_logs();
    do_redirect(32'h0000_0300);
    cycle();
    do_redirect(32'h0000_0400);
    for (int i = 0; i < 15; i++) cycle();
    check("double_first_pc", got_pc[0], 32'h0000_0400);
    check_stream("double_stream", 32'h0000_0400, 5);

    // Address wrap; low redirect bits ignored
    lat = 1;
    do_redirect(32'hFFFF_FFFB);
    check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    clear_logs();
    for (int i = 0; i < 10; i++) cycle();
    check("wrap_gnt", gnt_addr[2], 32'h0000_0000);
    check("wrap_pc", got_pc[2], 32'h0000_0000);
    check("wrap_instr", got_instr[2], KEY);
    check("wrap_next", got_pc[3], 32'h0000_0004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction memory port and the pipelined core's fetch stage. It issues sequential word fetch requests to a variable-latency instruction memory and buffers the in-order responses in a small FIFO. It presents `{instr, instr_pc}` to the core's Fetch/Decode boundary, and it discards the queue plus any in-flight responses when the core redirects on a taken branch.

## Interface
- `DEPTH`, 4: queue entries; also the maximum number of outstanding requests. Power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: word-aligned fetch address; bits [1:0] are always 0.
- `imem_gnt` in 1: request accepted this cycle. Sampled only when `imem_req`=1.
- `imem_rvalid` in 1: response valid. Exactly one response per grant, returned in order, earliest the cycle after the grant.
- `imem_rdata` in 32: response instruction word.
- `instr_valid` out 1: queue head valid.
- `instr` out 32: head instruction.
- `instr_pc` out 32: address of the head instruction.
- `instr_ready` in 1: the core consumes the head this cycle. Driven as `!StallF`.
- `redirect` in 1: taken branch; flush and refetch. Driven by `BranchTakenE`.
- `redirect_pc` in 32: new fetch address. Bits [1:0] are ignored and forced to 0.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - FIFO holding `DEPTH` entries of `{pc, instr}` with read and write pointers plus a count from 0 to DEPTH.
  - `live`: count of granted, not-yet-returned requests belonging to the current stream.
  - `stale`: count of granted requests whose responses must be dropped.
  - `resp_pc`: address of the next live response.
- Request issue:
  - `imem_req` = (count + live < DEPTH) && (live + stale < DEPTH) && !redirect.
  - `imem_addr` = `fetch_pc`.
  - On grant: `fetch_pc` += 4 (mod 2^32, wraps to 0), and `live` += 1.
- Response:
  - If `stale` > 0: drop the response and decrement `stale`.
  - Otherwise: push `{resp_pc, imem_rdata}`, increment `resp_pc` by 4, and decrement `live`.
  - Stale responses always precede live ones because memory ordering is preserved.
- Pop: when `instr_valid && instr_ready`, advance the read pointer.
- Simultaneous push and pop are allowed at any count. The issue credit guarantees the FIFO never overflows. A response arriving with count = DEPTH is a protocol violation and is flagged by an assertion in simulation.
- Redirect has priority over every other event in the same cycle:
  - FIFO count becomes 0, and any pop is ignored.
  - `fetch_pc` and `resp_pc` both become `redirect_pc`.
  - `stale` becomes stale + live, plus 1 if a request is granted this cycle, minus 1 if a response arrives this cycle. The arriving response is dropped.
  - `live` becomes 0.
  - `imem_req` is 0 during the redirect cycle.
- Redirect while `stale` > 0 accumulates correctly, and `stale` never exceeds DEPTH.

## Timing
- Reset (asynchronous assertion, low):
  - `imem_req`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - `fetch_pc`=`resp_pc`=RESET_PC.
  - `live`=`stale`=count=0.
  - `imem_addr`=RESET_PC.
- First cycle after reset release: `imem_req`=1 with `imem_addr`=RESET_PC.
- Reset mid-operation discards everything. Responses still owed by memory for requests granted before reset are the system's responsibility: memory is reset together with this block.
- Latency, bypass disabled: a response at cycle N is visible as the head at cycle N+1.
- Sustained throughput: one instruction per cycle with 1-cycle memory and DEPTH ≥ 2.
- Redirect at cycle R: `imem_req`=1 at R+1 with `imem_addr`=`redirect_pc`. `instr_valid`=0 from R+1 until the first live response has been pushed.
- `instr`/`instr_pc` hold their value while `instr_valid`=1 and `instr_ready`=0.

## Configuration
- `FETCHQ_BYPASS_EN` defined:
  - When the FIFO is empty, `stale`=0, `imem_rvalid`=1 and there is no redirect, the response drives `instr_valid`/`instr`/`instr_pc` combinationally in the same cycle.
  - If `instr_ready`=1 that cycle, the entry is not written. Otherwise it is pushed as normal.
  - Head latency is 0 cycles after the response.
- `FETCHQ_BYPASS_EN` undefined: outputs come from the FIFO head only, with registered-path latency of 1 cycle. The issue rule is unchanged in both builds.

## Test plan
- Reset with RESET_PC=0x100, 1-cycle memory, `instr_ready`=1 -> requests 0x100, 0x104, 0x108…. The core sees `instr_pc`=0x100 at reset+3 (reset+2 with bypass), then one instruction per cycle.
- `instr_ready`=0 for 10 cycles with DEPTH=4 -> `imem_req` drops once count + live = 4. No overflow occurs, and `instr`/`instr_pc` stay stable. After release, 4 consecutive instructions follow in order.
- 3-cycle memory with 3 in flight, `redirect`=1 with `redirect_pc`=0x200 -> the 3 old responses are dropped. The next `instr_pc` seen is 0x200 and no old word ever appears.
- `redirect` in the same cycle as `imem_gnt` and `imem_rvalid` -> `stale` accounts for +1 and -1. The stream resumes at `redirect_pc` with no lost or duplicated instruction.
- Two redirects 1 cycle apart (0x300, then 0x400) -> the only instructions delivered start at 0x400.
- `fetch_pc`=0xFFFF_FFFC -> the next request is at address 0x0000_0000.
